// File: rtl/engine_op_sched.sv
// Layer-command scheduler: runs an engine through repeated reset/start/wait passes.
// Optional WAIT watchdog is compiled in when ENGINE_SCHED_WDT_EN is defined.
module engine_op_sched #(
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 16,
    parameter int WDT_CYCLES = 1048576
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_type,
    input  logic [31:0]      cmd_op_num,
    input  logic [CNT_W-1:0] cmd_passes,
    input  logic             abort,
    input  logic             err_clr,
    output logic             engine_rst,
    output logic             conv_ready,
    output logic             maxpool_ready,
    output logic             avepool_ready,
    output logic [2:0]       op_type,
    output logic [31:0]      op_num,
    input  logic             conv_valid,
    input  logic             maxpool_valid,
    input  logic             avepool_valid,
    output logic             busy,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             cmd_done,
    output logic             abort_done,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {
        IDLE, ENG_RST, ARM, WAIT, RELEASE, DONE, FLUSH, ERR
    } state_t;

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t           state, nxt;
    logic [CNT_W-1:0] passes;
    logic [RC_W-1:0]  rst_cnt;
    logic             accept, bad_type, rst_last, pass_last;
    logic             is_conv, is_mpool, is_apool, match_valid, wdt_hit;

    assign accept      = cmd_valid && cmd_ready;
    assign bad_type    = (cmd_type == 3'd0) || (cmd_type > 3'd5);
    assign rst_last    = (rst_cnt == RC_W'(RST_CYCLES - 1));
    assign pass_last   = ((iter_cnt + 1'b1) == passes);
    assign is_conv     = (op_type == 3'd1) || (op_type == 3'd2) || (op_type == 3'd3);
    assign is_mpool    = (op_type == 3'd4);
    assign is_apool    = (op_type == 3'd5);
    assign match_valid = (is_conv && conv_valid) || (is_mpool && maxpool_valid) ||
                         (is_apool && avepool_valid);

`ifdef ENGINE_SCHED_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_cnt;

    // Held at zero outside WAIT so every WAIT entry starts a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             wdt_cnt <= '0;
        else if (state != WAIT) wdt_cnt <= '0;
        else                    wdt_cnt <= wdt_cnt + 1'b1;
    end

    assign wdt_hit = (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
`else
    assign wdt_hit = (WDT_CYCLES < 0);
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad_type)              nxt = ERR;
                    else if (cmd_passes == '0) nxt = DONE;
                    else                       nxt = ENG_RST;
                end
            end
            ENG_RST: begin
                if (abort)         nxt = FLUSH;
                else if (rst_last) nxt = ARM;
            end
            ARM:     nxt = abort ? FLUSH : WAIT;
            WAIT: begin
                if (abort)            nxt = FLUSH;
                else if (match_valid) nxt = RELEASE;
                else if (wdt_hit)     nxt = ERR;
            end
            RELEASE: begin
                if (abort)          nxt = FLUSH;
                else if (pass_last) nxt = DONE;
                else                nxt = ENG_RST;
            end
            DONE:    nxt = IDLE;
            FLUSH:   if (rst_last) nxt = IDLE;
            ERR:     if (err_clr) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Every output is a registered function of the next state so it lines up with that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            engine_rst    <= 1'b1;
            conv_ready    <= 1'b0;
            maxpool_ready <= 1'b0;
            avepool_ready <= 1'b0;
            op_type       <= '0;
            op_num        <= '0;
            passes        <= '0;
            iter_cnt      <= '0;
            rst_cnt       <= '0;
            busy          <= 1'b0;
            cmd_done      <= 1'b0;
            abort_done    <= 1'b0;
            err           <= 1'b0;
            err_code      <= 2'b00;
        end else begin
            state         <= nxt;
            cmd_ready     <= (nxt == IDLE);
            busy          <= !((nxt == IDLE) || (nxt == ERR));
            engine_rst    <= !((nxt == ARM) || (nxt == WAIT) || (nxt == RELEASE));
            conv_ready    <= (nxt == WAIT) && is_conv;
            maxpool_ready <= (nxt == WAIT) && is_mpool;
            avepool_ready <= (nxt == WAIT) && is_apool;
            cmd_done      <= (nxt == DONE);
            abort_done    <= (state == FLUSH) && (nxt == IDLE);
            err           <= (nxt == ERR);

            if (nxt != ERR)        err_code <= 2'b00;
            else if (state != ERR) err_code <= (state == IDLE) ? 2'b01 : 2'b10;

            if ((state == nxt) && ((state == ENG_RST) || (state == FLUSH)))
                rst_cnt <= rst_cnt + 1'b1;
            else
                rst_cnt <= '0;

            if (accept) begin
                op_type  <= cmd_type;
                op_num   <= cmd_op_num;
                passes   <= cmd_passes;
                iter_cnt <= '0;
            end else if ((state == RELEASE) && (nxt != FLUSH)) begin
                iter_cnt <= iter_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_engine_op_sched.sv
// Randomized scoreboard bench for engine_op_sched with a behavioural engine model.
// Watchdog scenario runs only when ENGINE_SCHED_WDT_EN is defined.
module tb_engine_op_sched;

    localparam int RST   = 2;
    localparam int CNT_W = 16;
    localparam int WDT   = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_type = '0;
    logic [31:0]      cmd_op_num = '0;
    logic [CNT_W-1:0] cmd_passes = '0;
    logic             abort = 1'b0;
    logic             err_clr = 1'b0;
    logic             engine_rst, conv_ready, maxpool_ready, avepool_ready;
    logic [2:0]       op_type;
    logic [31:0]      op_num;
    logic             conv_valid = 1'b0, maxpool_valid = 1'b0, avepool_valid = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] iter_cnt;
    logic             cmd_done, abort_done, err;
    logic [1:0]       err_code;

    engine_op_sched #(.RST_CYCLES(RST), .CNT_W(CNT_W), .WDT_CYCLES(WDT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_op_num(cmd_op_num), .cmd_passes(cmd_passes),
        .abort(abort), .err_clr(err_clr), .engine_rst(engine_rst),
        .conv_ready(conv_ready), .maxpool_ready(maxpool_ready), .avepool_ready(avepool_ready),
        .op_type(op_type), .op_num(op_num), .conv_valid(conv_valid),
        .maxpool_valid(maxpool_valid), .avepool_valid(avepool_valid), .busy(busy),
        .iter_cnt(iter_cnt), .cmd_done(cmd_done), .abort_done(abort_done),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;    // 0 = cmd_done, 1 = abort_done, 2 = err
        int          iter;
        logic [1:0]  code;
        logic [23:0] pulses;  // ready rising edges: [7:0] conv, [15:8] maxpool, [23:16] avepool
        logic [2:0]  typ;
        logic [31:0] num;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Engine model controls
    int   delay = 20;
    bit   mute = 0;
    bit   noise_on = 0;
    int   cur_line = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int line_of(input logic [2:0] t);
        if (t >= 3'd1 && t <= 3'd3) return 0;
        if (t == 3'd4) return 1;
        return 2;
    endfunction

    // Outcome of one command from the command-level rules alone.
    function automatic exp_t model(input logic [2:0] t, input logic [31:0] n, input int p,
                                   input int abort_k, input bit wdt);
        exp_t e;
        e.typ = t; e.num = n; e.code = 2'b00; e.pulses = '0; e.iter = 0; e.kind = 0;
        if (t == 3'd0 || t > 3'd5) begin
            e.kind = 2; e.code = 2'b01;
        end else if (p == 0) begin
            e.kind = 0;
        end else if (abort_k >= 0) begin
            e.kind = 1; e.iter = abort_k;
            e.pulses = 24'(abort_k + 1) << (8 * line_of(t));
        end else if (wdt) begin
            e.kind = 2; e.code = 2'b10;
            e.pulses = 24'(1) << (8 * line_of(t));
        end else begin
            e.kind = 0; e.iter = p;
            e.pulses = 24'(p) << (8 * line_of(t));
        end
        return e;
    endfunction

    // Engine: raises the matching valid (level) `delay` cycles after its ready, drops it with ready.
    initial begin
        int  ecnt [3];
        bit  ev   [3];
        logic [2:0] r;
        for (int i = 0; i < 3; i++) begin ecnt[i] = 0; ev[i] = 0; end
        forever begin
            @(negedge clk);
            r = {avepool_ready, maxpool_ready, conv_ready};
            for (int i = 0; i < 3; i++) begin
                if (r[i] && !mute) begin
                    ecnt[i]++;
                    ev[i] = (ecnt[i] >= delay);
                end else begin
                    ecnt[i] = 0;
                    ev[i] = 0;
                end
            end
            conv_valid    = ev[0] | (noise_on && cur_line != 0);
            maxpool_valid = ev[1] | (noise_on && cur_line != 1);
            avepool_valid = ev[2] | (noise_on && cur_line != 2);
        end
    end

    // Monitor: pops the scoreboard on every completion event and tracks cycle invariants.
    int viol = 0;
    initial begin
        logic [23:0] n_rdy;
        logic [2:0]  rdy, prev_rdy;
        int          rst_run, last_run, kind;
        logic [CNT_W-1:0] prev_iter;
        bit          pend_rdy, err_prev, done_prev, ab_prev;
        exp_t        e;
        n_rdy = '0; prev_rdy = '0; rst_run = 0; last_run = 0; prev_iter = '0;
        pend_rdy = 0; err_prev = 0; done_prev = 0; ab_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n_rdy = '0; prev_rdy = '0; rst_run = 0; last_run = 0; prev_iter = '0;
                pend_rdy = 0; err_prev = 0; done_prev = 0; ab_prev = 0; viol = 0;
            end else begin
                rdy = {avepool_ready, maxpool_ready, conv_ready};
                if (pend_rdy) begin
                    chk("cmd_ready_after_done", cmd_ready, 1'b1);
                    pend_rdy = 0;
                end
                if ($countones(rdy) > 1 || (rdy != 3'b000 && engine_rst)) viol++;
                if (engine_rst) rst_run++;
                else begin
                    if (rst_run != 0) last_run = rst_run;
                    rst_run = 0;
                end
                for (int i = 0; i < 3; i++)
                    if (rdy[i] && !prev_rdy[i]) begin
                        n_rdy[8*i +: 8] = n_rdy[8*i +: 8] + 8'd1;
                        if (last_run < RST) viol++;
                    end
                if (iter_cnt != prev_iter && iter_cnt != '0 && iter_cnt != prev_iter + 1'b1) viol++;
                if ((cmd_done && done_prev) || (abort_done && ab_prev)) viol++;

                if (cmd_done || abort_done || (err && !err_prev)) begin
                    kind = cmd_done ? 0 : (abort_done ? 1 : 2);
                    if (q.size() == 0) begin
                        chk("unexpected_event", 64'(kind), 64'hFF);
                    end else begin
                        e = q.pop_front();
                        chk("event_kind", 64'(kind), 64'(e.kind));
                        chk("iter_cnt", iter_cnt, 64'(e.iter));
                        chk("err_code", err_code, e.code);
                        chk("ready_pulses", n_rdy, e.pulses);
                        chk("op_type", op_type, e.typ);
                        chk("op_num", op_num, e.num);
                        chk("invariants", 64'(viol), 64'd0);
                    end
                    n_rdy = '0;
                    viol = 0;
                    if (cmd_done) pend_rdy = 1;
                end
                prev_rdy = rdy; prev_iter = iter_cnt;
                err_prev = err; done_prev = cmd_done; ab_prev = abort_done;
            end
        end
    end

    task automatic issue(input logic [2:0] t, input logic [31:0] n, input logic [CNT_W-1:0] p);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("cmd_ready_wait", ok, 1'b1);
        cmd_valid = 1'b1; cmd_type = t; cmd_op_num = n; cmd_passes = p;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_type = 3'($urandom); cmd_op_num = $urandom; cmd_passes = CNT_W'($urandom);
    endtask

    task automatic finish_cmd(input int abort_k);
        bit seen;
        int lat;
        if (abort_k >= 0) begin
            seen = 0;
            for (int i = 0; i < 3000; i++) begin
                if ((conv_ready || maxpool_ready || avepool_ready) && iter_cnt == CNT_W'(abort_k)) begin
                    seen = 1; break;
                end
                @(negedge clk);
            end
            chk("abort_target_wait", seen, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_ready_drop", {conv_ready, maxpool_ready, avepool_ready, engine_rst}, 4'b0001);
        end
        seen = 0; lat = 0;
        for (int i = 0; i < 3000; i++) begin
            if (cmd_done || abort_done || err) begin seen = 1; lat = i; break; end
            @(negedge clk);
        end
        chk("completion_wait", seen, 1'b1);
        if (abort_k >= 0 && seen) chk("flush_len", 64'(lat), 64'(RST));
        if (err) begin
            chk("err_state", {cmd_ready, busy, engine_rst, conv_ready, maxpool_ready, avepool_ready},
                6'b001000);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            chk("err_clear", {err, err_code, cmd_ready}, 4'b0001);
        end
    endtask

    task automatic run_cmd(input logic [2:0] t, input logic [31:0] n, input int p,
                           input int d, input bit nz, input int abort_k);
        delay = d; noise_on = nz; cur_line = line_of(t);
        q.push_back(model(t, n, p, abort_k, 1'b0));
        issue(t, n, CNT_W'(p));
        if (!(t == 3'd0 || t > 3'd5) && p == 0)
            chk("zero_pass_done", {cmd_done, engine_rst}, 2'b11);
        finish_cmd(abort_k);
        noise_on = 0;
    endtask

    initial begin
        logic [2:0] t;
        int p, ak, wcnt;
        bit ok;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ctrl", {cmd_ready, engine_rst, conv_ready, maxpool_ready, avepool_ready, busy},
            6'b110000);
        chk("reset_status", {cmd_done, abort_done, err, err_code}, 5'b0);
        chk("reset_regs", {op_type, op_num, iter_cnt}, 51'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(3'd2, 32'd9, 3, 20, 1'b0, -1);        // CONV3, three passes
        run_cmd(3'd4, 32'd100, 1, 12, 1'b1, -1);      // MPOOL with foreign valids high
        run_cmd(3'd7, 32'd5, 2, 5, 1'b0, -1);         // illegal type
        run_cmd(3'd5, 32'd33, 0, 5, 1'b0, -1);        // zero passes
        run_cmd(3'd3, 32'd44, 4, 15, 1'b0, 1);        // abort in pass 2 of 4

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0: t = 3'd0;
                    1: t = 3'd6;
                    default: t = 3'd7;
                endcase
            end else begin
                t = 3'($urandom_range(1, 5));
            end
            p = $urandom_range(0, 4);
            ak = (!(t == 3'd0 || t > 3'd5) && p > 0 && $urandom_range(0, 3) == 0)
                 ? $urandom_range(0, p - 1) : -1;
            run_cmd(t, $urandom, p, (ak >= 0) ? $urandom_range(10, 30) : $urandom_range(1, 30),
                    1'($urandom_range(0, 1)), ak);
        end

        // Asynchronous reset in the middle of WAIT
        mute = 1; cur_line = 0;
        issue(3'd1, 32'h77, 16'd3);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (conv_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("rst_test_wait", ok, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wait", {conv_ready, engine_rst, cmd_ready, busy, op_type}, 7'b0110000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mute = 0;
        @(negedge clk);

`ifdef ENGINE_SCHED_WDT_EN
        mute = 1; cur_line = 0; noise_on = 0;
        q.push_back(model(3'd1, 32'h55, 2, -1, 1'b1));
        issue(3'd1, 32'h55, 16'd2);
        wcnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (err) break;
            if (conv_ready) wcnt++;
            @(negedge clk);
        end
        chk("wdt_wait_cycles", 64'(wcnt), 64'(WDT));
        finish_cmd(-1);
        mute = 0;
`else
        wcnt = 0;
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        chk("final_invariants", 64'(viol), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
